seq_detect_ctrl: RTL and testbench

Controller that sequences the team's serial two-ones Moore detector over parallel data words. It accepts a WORD_W-bit word on a valid/ready handshake, clears the detector, and shifts the word into it MSB-first. It counts the cycles in which the detector output is high and returns the count on a valid/ready result port. It sits between a word-oriented producer and the bit-serial detector datapath.

---
 rtl/seq_detect_ctrl.sv | 143 ++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_ctrl
// Description : Sequences a serial two-ones Moore detector over parallel words
//               and counts detector hits. Optional: SEQ_DETECT_CTRL_CARRY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              det_rst,
    output logic              det_bit,
    input  logic              det_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  hit_count,
    output logic              any_hit,
    output logic              busy
);

`ifdef SEQ_DETECT_CTRL_CARRY_EN
    localparam bit CARRY = 1'b1;
`else
    localparam bit CARRY = 1'b0;
`endif

    localparam int IDX_W = $clog2(WORD_W);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [2:0]        state_q, state_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              det_bit_q, det_bit_d;
    logic              out_valid_q, out_valid_d;
    logic              any_q, any_d;

    logic              w_accept;
    logic              w_sample;
    logic [WORD_W-1:0] w_src;

    assign w_accept = in_valid && (state_q == S_IDLE);

    // Detector output lags the driven bit by one cycle, so the first SHIFT
    // sample only shows the cleared state unless state carries over.
    assign w_sample = ((state_q == S_SHIFT) && (CARRY || (idx_q != '0)))
                   || (state_q == S_DRAIN);

    assign w_src = (state_q == S_IDLE) ? in_data : sh_q;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = CARRY ? S_SHIFT : S_CLEAR;
            S_CLEAR: state_d = S_SHIFT;
            S_SHIFT: if (idx_q == IDX_LAST) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- state decode
    always_comb begin
        in_ready = (state_q == S_IDLE);
        busy     = (state_q != S_IDLE);
        det_rst  = reset || (state_q == S_CLEAR);
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        det_bit_d   = 1'b0;
        idx_d       = ((state_q == S_SHIFT) && (idx_q != IDX_LAST))
                    ? idx_q + IDX_W'(1) : '0;
        out_valid_d = (state_d == S_DONE);

        if (w_accept) begin
            sh_d  = in_data;
            cnt_d = '0;
        end else if (w_sample && det_out && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // det_bit is registered, so the next bit is loaded one edge ahead
        if (state_d == S_SHIFT) begin
            det_bit_d = w_src[WORD_W-1];
            sh_d      = {w_src[WORD_W-2:0], 1'b0};
        end

        any_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q        <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            det_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            any_q       <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            det_bit_q   <= det_bit_d;
            out_valid_q <= out_valid_d;
            any_q       <= any_d;
        end
    end

    assign det_bit   = det_bit_q;
    assign out_valid = out_valid_q;
    assign hit_count = cnt_q;
    assign any_hit   = any_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_ctrl
// Description : Scoreboard bench for seq_detect_ctrl with a detector model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          det_rst;
    logic          det_bit;
    logic          det_out;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] hit_count;
    logic          any_hit;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.WORD_W(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .det_rst   (det_rst),
        .det_bit   (det_bit),
        .det_out   (det_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hit_count (hit_count),
        .any_hit   (any_hit),
        .busy      (busy)
    );

    // Two-ones Moore detector: length of current run of ones, capped at 2
    int run = 0;
    always @(posedge clk) begin
        if (det_rst) run <= 0;
        else         run <= det_bit ? ((run >= 2) ? 2 : run + 1) : 0;
    end
    assign det_out = (run >= 2);

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Hits = number of adjacent bit pairs that are both one
    function automatic int exp_count(input logic [W-1:0] w);
        logic [W-1:0] p;
        p = w & (w >> 1);
        return $countones(p);
    endfunction

    // Timing model: m_k = edges since the accept edge
    bit           m_busy = 1'b0;
    int           m_k    = 0;
    logic [W-1:0] m_word = '0;
    int           exp_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_k    <= 0;
        end else if (m_busy) begin
            if (m_k >= W + 2 && out_ready) m_busy <= 1'b0;
            else                           m_k    <= m_k + 1;
        end else if (in_valid) begin
            m_busy <= 1'b1;
            m_k    <= 0;
            m_word <= in_data;
        end
    end

    always @(posedge clk) begin
        if (!reset && m_busy && m_k >= W + 2 && out_ready && exp_q.size() > 0)
            void'(exp_q.pop_front());
    end

    // Monitor
    always @(negedge clk) begin
        logic eb;
        eb = (m_busy && m_k >= 1 && m_k <= W) ? m_word[W - m_k] : 1'b0;
        check("in_ready",  in_ready,  !m_busy);
        check("busy",      busy,      m_busy);
        check("out_valid", out_valid, m_busy && m_k >= W + 2);
        check("det_rst",   det_rst,   reset || (m_busy && m_k == 0));
        check("det_bit",   det_bit,   eb);
        if (reset) begin
            check("rst_hit_count", hit_count, 0);
            check("rst_any_hit",   any_hit,   0);
        end else if (m_busy && m_k >= W + 2) begin
            check("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                check("hit_count", hit_count, exp_q[0]);
                check("any_hit",   any_hit,   exp_q[0] != 0);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle
    task automatic run_word(input logic [W-1:0] w, input int stall, input bit junk_valid);
        int t;
        in_valid  = 1'b1;
        in_data   = w;
        out_ready = (stall == 0);
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp_count(w));
        @(negedge clk);
        in_valid = junk_valid;
        in_data  = W'($urandom);
        t = 0;
        while (!out_valid && t < W + 10) begin
            @(negedge clk);
            in_data = W'($urandom);
            t++;
        end
        if (!out_valid) check("result_timeout", 0, 1);
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
    endtask

    task automatic mid_reset();
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        out_ready = 1'b1;
        check("mr_in_ready", in_ready, 1);
        exp_q.push_back(exp_count(8'hFF));
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mr_in_ready_rst",  in_ready,  1);
        check("mr_busy_rst",      busy,      0);
        check("mr_out_valid_rst", out_valid, 0);
        check("mr_det_bit_rst",   det_bit,   0);
        check("mr_det_rst_rst",   det_rst,   1);
        check("mr_hit_count_rst", hit_count, 0);
        check("mr_any_hit_rst",   any_hit,   0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        run_word(8'hF0, 0, 1'b0);
        run_word(8'hB6, 0, 1'b0);
        run_word(8'hFF, 0, 1'b0);
        run_word(8'h00, 0, 1'b0);
        run_word(8'hAA, 0, 1'b0);
        run_word(8'h5C, 5, 1'b1);
        mid_reset();
        run_word(8'h03, 0, 1'b0);
        run_word(8'hC0, 0, 1'b0);
        for (int i = 0; i < 40; i++)
            run_word(W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire
